// File: rtl/bit_to_byte_packer.sv
// bit_to_byte_packer
// Packs a 1-bit-per-beat AXI4-Stream into bytes on an 8-bit AXI4-Stream master.
// A beat carrying tlast flushes the partial byte: zero-padded, with tuser
// giving the number of valid bits (1..8).
// MSB_FIRST = 1 puts the first received bit in tdata[7]; 0 puts it in tdata[0].
// Optional feature: define B2B_BYTE_COUNTER_EN to add the byte_count output,
// a wrapping count of completed m_axis handshakes.
module bit_to_byte_packer #(
    parameter int MSB_FIRST = 1
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic [3:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
`ifdef B2B_BYTE_COUNTER_EN
    ,
    output logic [31:0] byte_count
`endif
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] acc_q, acc_d;
    logic [7:0] data_q, data_d;
    logic [3:0] user_q, user_d;
    logic       last_q, last_d;
    logic       valid_q, valid_d;

    logic       accept;
    logic       complete;
    logic [7:0] merged;
    logic [7:0] ordered;

    // Only a completing beat needs the output register free; other bits
    // are always taken, so up to 7 bits can pile in behind a stalled byte.
    assign s_axis_tready = !valid_q || m_axis_tready ||
                           (bit_cnt_q != 3'd7 && !s_axis_tlast);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (bit_cnt_q == 3'd7 || s_axis_tlast);

    // acc keeps bit k of the byte at index k; the output orientation is
    // applied only when the byte is loaded into the output register.
    always_comb begin
        merged            = {1'b0, acc_q};
        merged[bit_cnt_q] = s_axis_tdata;
        ordered           = merged;
        for (int i = 0; i < 8; i++) begin
            if (MSB_FIRST != 0) begin
                ordered[i] = merged[7-i];
            end else begin
                ordered[i] = merged[i];
            end
        end
    end

    // Packing state and output register update; a reload in the same cycle
    // as a handshake wins, so back-to-back bytes need no bubble.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        user_d    = user_q;
        last_d    = last_q;
        valid_d   = valid_q;

        if (accept) begin
            if (complete) begin
                bit_cnt_d = 3'd0;
                acc_d     = 7'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                acc_d     = merged[6:0];
            end
        end

        if (valid_q && m_axis_tready) begin
            data_d  = 8'd0;
            user_d  = 4'd0;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end

        if (complete) begin
            data_d  = ordered;
            user_d  = {1'b0, bit_cnt_q} + 4'd1;
            last_d  = s_axis_tlast;
            valid_d = 1'b1;
        end
    end

    // State registers; reset discards any partial or pending byte.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bit_cnt_q <= 3'd0;
            acc_q     <= 7'd0;
            data_q    <= 8'd0;
            user_q    <= 4'd0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            user_q    <= user_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;

`ifdef B2B_BYTE_COUNTER_EN
    logic [31:0] byte_count_q, byte_count_d;

    // Count every output handshake, partial bytes included; wraps naturally.
    always_comb begin
        byte_count_d = byte_count_q;
        if (valid_q && m_axis_tready) begin
            byte_count_d = byte_count_q + 32'd1;
        end
    end

    // Byte counter register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            byte_count_q <= 32'd0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_bit_to_byte_packer.sv
// Directed bench for bit_to_byte_packer: one MSB-first and one LSB-first
// instance share the same stimulus. Expected bytes are hand-computed.
module tb_bit_to_byte_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tdata = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       m_tready = 1'b1;

    logic       s_tready1, s_tready0;
    logic [7:0] m_tdata1, m_tdata0;
    logic [3:0] m_tuser1, m_tuser0;
    logic       m_tvalid1, m_tvalid0;
    logic       m_tlast1, m_tlast0;
`ifdef B2B_BYTE_COUNTER_EN
    logic [31:0] count1, count0;
`endif

    int errors = 0;
    int checks = 0;

    // captured output beats: {tlast, tuser, tdata}
    logic [12:0] q1[$];
    logic [12:0] q0[$];

    always #5 clk = ~clk;

    bit_to_byte_packer #(.MSB_FIRST(1)) dut1 (
        .ACLK(clk), .ARESETN(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata1), .m_axis_tuser(m_tuser1),
        .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast1)
`ifdef B2B_BYTE_COUNTER_EN
        , .byte_count(count1)
`endif
    );

    bit_to_byte_packer #(.MSB_FIRST(0)) dut0 (
        .ACLK(clk), .ARESETN(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready0), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata0), .m_axis_tuser(m_tuser0),
        .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast0)
`ifdef B2B_BYTE_COUNTER_EN
        , .byte_count(count0)
`endif
    );

    always @(posedge clk) begin
        if (m_tvalid1 && m_tready) q1.push_back({m_tlast1, m_tuser1, m_tdata1});
        if (m_tvalid0 && m_tready) q0.push_back({m_tlast0, m_tuser0, m_tdata0});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one bit from a negedge and return at the negedge after it is accepted.
    task automatic send_bit(input logic b, input logic l);
        int  n;
        logic ok;
        n = 0;
        s_tdata  = b;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            #1;
            ok = s_tready1;
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 200) begin
                errors++;
                checks++;
                $display("FAIL send_bit_timeout got=stalled exp=accepted");
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic last8);
        for (int i = 7; i >= 0; i--) send_bit(v[i], last8 && (i == 0));
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q1.delete();
        q0.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_tvalid1, m_tdata1, m_tuser1, m_tlast1, s_tready1} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            begin errors++; $display("FAIL reset_dut1 got=%h exp=%h", {m_tvalid1, m_tdata1, m_tuser1, m_tlast1, s_tready1}, {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}); end
        checks++;
        if ({m_tvalid0, m_tdata0, m_tuser0, m_tlast0, s_tready0} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            begin errors++; $display("FAIL reset_dut0 got=%h exp=%h", {m_tvalid0, m_tdata0, m_tuser0, m_tlast0, s_tready0}, {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pack();
        logic [7:0]  v;
        logic [12:0] e1[$];
        logic [12:0] e0[$];
        v = 8'hA5;
        q1.delete(); q0.delete();
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        checks++;
        if (m_tvalid1 !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0", m_tvalid1); end
        send_bit(v[0], 1'b0);
        checks++;
        if ({m_tvalid1, m_tlast1, m_tuser1, m_tdata1} !== {1'b1, 1'b0, 4'd8, 8'hA5})
            begin errors++; $display("FAIL latency_dut1 got=%h exp=%h", {m_tvalid1, m_tlast1, m_tuser1, m_tdata1}, {1'b1, 1'b0, 4'd8, 8'hA5}); end
        checks++;
        if ({m_tvalid0, m_tlast0, m_tuser0, m_tdata0} !== {1'b1, 1'b0, 4'd8, 8'hA5})
            begin errors++; $display("FAIL latency_dut0 got=%h exp=%h", {m_tvalid0, m_tlast0, m_tuser0, m_tdata0}, {1'b1, 1'b0, 4'd8, 8'hA5}); end
        idle(1);
        checks++;
        if (m_tvalid1 !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got=%b exp=0", m_tvalid1); end
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        idle(3);
        e1 = '{{1'b0, 4'd8, 8'hA5}, {1'b1, 4'd3, 8'hC0}, {1'b1, 4'd3, 8'hA0}, {1'b1, 4'd1, 8'h80}};
        e0 = '{{1'b0, 4'd8, 8'hA5}, {1'b1, 4'd3, 8'h03}, {1'b1, 4'd3, 8'h05}, {1'b1, 4'd1, 8'h01}};
        checks++;
        if (q1.size() != e1.size() || q0.size() != e0.size())
            begin errors++; $display("FAIL pack_count got=%0d/%0d exp=%0d", q1.size(), q0.size(), e1.size()); end
        else for (int i = 0; i < e1.size(); i++) begin
            checks++;
            if (q1[i] !== e1[i]) begin errors++; $display("FAIL pack_dut1[%0d] got=%h exp=%h", i, q1[i], e1[i]); end
            checks++;
            if (q0[i] !== e0[i]) begin errors++; $display("FAIL pack_dut0[%0d] got=%h exp=%h", i, q0[i], e0[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        logic [12:0] e1[$];
        logic [12:0] e0[$];
        w = 32'hDEADBEEF;
        q1.delete(); q0.delete();
        for (int i = 31; i >= 25; i--) send_bit(w[i], 1'b0);
        fork
            begin
                m_tready = 1'b0;
                repeat (20) @(negedge clk);
                m_tready = 1'b1;
            end
            begin
                for (int i = 24; i >= 17; i--) send_bit(w[i], 1'b0);
                s_tdata  = w[16];
                s_tvalid = 1'b1;
                #1;
                checks++;
                if ({s_tready1, s_tready0} !== 2'b00)
                    begin errors++; $display("FAIL stall_tready got=%b exp=00", {s_tready1, s_tready0}); end
                checks++;
                if (q1.size() != 0) begin errors++; $display("FAIL stall_leak got=%0d exp=0", q1.size()); end
                send_bit(w[16], 1'b0);
                for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
            end
        join
        idle(3);
        e1 = '{{1'b0, 4'd8, 8'hDE}, {1'b0, 4'd8, 8'hAD}, {1'b0, 4'd8, 8'hBE}, {1'b0, 4'd8, 8'hEF}};
        e0 = '{{1'b0, 4'd8, 8'h7B}, {1'b0, 4'd8, 8'hB5}, {1'b0, 4'd8, 8'h7D}, {1'b0, 4'd8, 8'hF7}};
        checks++;
        if (q1.size() != e1.size() || q0.size() != e0.size())
            begin errors++; $display("FAIL bp_count got=%0d/%0d exp=%0d", q1.size(), q0.size(), e1.size()); end
        else for (int i = 0; i < e1.size(); i++) begin
            checks++;
            if (q1[i] !== e1[i]) begin errors++; $display("FAIL bp_dut1[%0d] got=%h exp=%h", i, q1[i], e1[i]); end
            checks++;
            if (q0[i] !== e0[i]) begin errors++; $display("FAIL bp_dut0[%0d] got=%h exp=%h", i, q0[i], e0[i]); end
        end
    endtask

    task automatic test_tlast_full();
        q1.delete(); q0.delete();
        send_byte(8'hFF, 1'b1);
        idle(4);
        checks++;
        if (q1.size() != 1 || q0.size() != 1)
            begin errors++; $display("FAIL tlast8_count got=%0d/%0d exp=1", q1.size(), q0.size()); end
        else begin
            checks++;
            if (q1[0] !== {1'b1, 4'd8, 8'hFF}) begin errors++; $display("FAIL tlast8_dut1 got=%h exp=%h", q1[0], {1'b1, 4'd8, 8'hFF}); end
            checks++;
            if (q0[0] !== {1'b1, 4'd8, 8'hFF}) begin errors++; $display("FAIL tlast8_dut0 got=%h exp=%h", q0[0], {1'b1, 4'd8, 8'hFF}); end
        end
    endtask

    task automatic test_idle_gaps();
        logic [7:0] v;
        v = 8'h96;
        q1.delete(); q0.delete();
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], 1'b0);
            idle(2);
        end
        checks++;
        if (q1.size() != 1 || q0.size() != 1)
            begin errors++; $display("FAIL gaps_count got=%0d/%0d exp=1", q1.size(), q0.size()); end
        else begin
            checks++;
            if (q1[0] !== {1'b0, 4'd8, 8'h96}) begin errors++; $display("FAIL gaps_dut1 got=%h exp=%h", q1[0], {1'b0, 4'd8, 8'h96}); end
            checks++;
            if (q0[0] !== {1'b0, 4'd8, 8'h69}) begin errors++; $display("FAIL gaps_dut0 got=%h exp=%h", q0[0], {1'b0, 4'd8, 8'h69}); end
        end
    endtask

    task automatic test_reset_mid();
        q1.delete(); q0.delete();
        m_tready = 1'b0;
        send_byte(8'h81, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        s_tvalid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if ({m_tvalid1, m_tdata1, m_tuser1, m_tlast1, s_tready1} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            begin errors++; $display("FAIL midreset_dut1 got=%h exp=%h", {m_tvalid1, m_tdata1, m_tuser1, m_tlast1, s_tready1}, {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}); end
        checks++;
        if ({m_tvalid0, m_tdata0, m_tuser0, m_tlast0, s_tready0} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1})
            begin errors++; $display("FAIL midreset_dut0 got=%h exp=%h", {m_tvalid0, m_tdata0, m_tuser0, m_tlast0, s_tready0}, {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}); end
        @(negedge clk);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        send_byte(8'h3C, 1'b0);
        idle(3);
        checks++;
        if (q1.size() != 1 || q0.size() != 1)
            begin errors++; $display("FAIL midreset_count got=%0d/%0d exp=1", q1.size(), q0.size()); end
        else begin
            checks++;
            if (q1[0] !== {1'b0, 4'd8, 8'h3C}) begin errors++; $display("FAIL midreset_byte1 got=%h exp=%h", q1[0], {1'b0, 4'd8, 8'h3C}); end
            checks++;
            if (q0[0] !== {1'b0, 4'd8, 8'h3C}) begin errors++; $display("FAIL midreset_byte0 got=%h exp=%h", q0[0], {1'b0, 4'd8, 8'h3C}); end
        end
    endtask

`ifdef B2B_BYTE_COUNTER_EN
    task automatic test_byte_count();
        apply_reset();
        for (int i = 0; i < 10; i++) send_byte(8'h55, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(3);
        checks++;
        if (count1 !== 32'd11) begin errors++; $display("FAIL count_dut1 got=%0d exp=11", count1); end
        checks++;
        if (count0 !== 32'd11) begin errors++; $display("FAIL count_dut0 got=%0d exp=11", count0); end
        force dut1.byte_count_q = 32'hFFFF_FFFF;
        force dut0.byte_count_q = 32'hFFFF_FFFF;
        #1;
        release dut1.byte_count_q;
        release dut0.byte_count_q;
        @(negedge clk);
        send_byte(8'hC3, 1'b0);
        idle(3);
        checks++;
        if (count1 !== 32'd0) begin errors++; $display("FAIL count_wrap1 got=%h exp=0", count1); end
        checks++;
        if (count0 !== 32'd0) begin errors++; $display("FAIL count_wrap0 got=%h exp=0", count0); end
    endtask
`endif

    initial begin
        test_reset();
        test_pack();
        test_backpressure();
        test_tlast_full();
        test_idle_gaps();
        test_reset_mid();
`ifdef B2B_BYTE_COUNTER_EN
        test_byte_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
